// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults, FSM states and helpers for the conv line buffer
package conv_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_W          = 48;
  localparam int DEF_H          = 48;
  localparam int DEF_F          = 3;
  localparam int NUM_BANKS      = 4;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {FILL, ISSUE, BUSY} state_t;

  // Index width that stays at least 1 bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_line_buffer_if.sv
// rtl/conv_line_buffer_if.sv - pixel stream in, three-row window out, conv handshake
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W          = DEF_W
);
  logic [DATA_WIDTH-1:0]   in_pixel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    conv_done;
  logic [0:W*DATA_WIDTH-1] image0;
  logic [0:W*DATA_WIDTH-1] image1;
  logic [0:W*DATA_WIDTH-1] image2;
  logic                    row_start;
  logic                    frame_done;

  modport master (
    output in_pixel, in_valid, conv_done,
    input  in_ready, image0, image1, image2, row_start, frame_done
  );

  modport slave (
    input  in_pixel, in_valid, conv_done,
    output in_ready, image0, image1, image2, row_start, frame_done
  );
endinterface

// File: rtl/line_bank.sv
// rtl/line_bank.sv - one W-pixel register row with column write and full-row read
module line_bank
  import conv_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int W          = DEF_W,
  localparam int CW         = idx_width(W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [CW-1:0]           col,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [0:W*DATA_WIDTH-1] row
);
  logic [DATA_WIDTH-1:0] mem [W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[col] <= wdata;
    end
  end

  for (genvar c = 0; c < W; c++) begin : g_pack
    assign row[c*DATA_WIDTH +: DATA_WIDTH] = mem[c];
  end
endmodule

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - 4-bank row ring presenting 3-row windows to the conv stage
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int W          = DEF_W,
  parameter int H          = DEF_H,
  parameter int F          = DEF_F
) (
  input logic clk,
  input logic reset,
  conv_line_buffer_if.slave bus
);
  localparam int CW = idx_width(W);
  localparam int RW = idx_width(H + 1);

  if (F != 3) begin : g_bad_f
    $error("conv_line_buffer: F must be 3");
  end

  state_t                  state, state_next;
  logic [CW-1:0]           col;
  logic [RW-1:0]           r, w;
  logic                    frame_done_q;
  logic [0:W*DATA_WIDTH-1] image0_q, image1_q, image2_q;
  logic [0:W*DATA_WIDTH-1] bank_row [NUM_BANKS];
  logic [RW:0]             w_plus3;
  logic                    ready_c, accept, window_ready, last_window, last_col;
  logic                    load_window, advance, finish;
  logic [1:0]              sel0, sel1, sel2;

  assign w_plus3      = {1'b0, w} + (RW+1)'(3);
  assign window_ready = ({1'b0, r} >= w_plus3);
  assign last_window  = (w == RW'(H - F));
  assign last_col     = (col == CW'(W - 1));
  // Never write into a bank the active window still reads; frame_done gates the cleared frame.
  assign ready_c      = !reset && !frame_done_q && (r < RW'(H)) && ({1'b0, r} <= w_plus3);
  assign accept       = bus.in_valid && ready_c;

  assign sel0 = w[1:0];
  assign sel1 = w[1:0] + 2'd1;
  assign sel2 = w[1:0] + 2'd2;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    line_bank #(.DATA_WIDTH(DATA_WIDTH), .W(W)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (accept && (r[1:0] == 2'(b))),
      .col   (col),
      .wdata (bus.in_pixel),
      .row   (bank_row[b])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_window = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      FILL: if (window_ready) begin
        state_next  = ISSUE;
        load_window = 1'b1;
      end
      ISSUE: state_next = BUSY;
      BUSY: if (bus.conv_done) begin
        state_next = FILL;
        if (last_window) finish  = 1'b1;
        else             advance = 1'b1;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      r            <= '0;
      w            <= '0;
      frame_done_q <= 1'b0;
      image0_q     <= '0;
      image1_q     <= '0;
      image2_q     <= '0;
    end else begin
      frame_done_q <= finish;
      if (finish) begin
        col <= '0;
        r   <= '0;
        w   <= '0;
      end else begin
        if (accept) begin
          if (last_col) begin
            col <= '0;
            r   <= r + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        if (advance) w <= w + RW'(1);
      end
      if (load_window) begin
        image0_q <= bank_row[sel0];
        image1_q <= bank_row[sel1];
        image2_q <= bank_row[sel2];
      end
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.row_start  = (state == ISSUE);
  assign bus.frame_done = frame_done_q;
  assign bus.image0     = image0_q;
  assign bus.image1     = image1_q;
  assign bus.image2     = image2_q;
endmodule
